// File: rtl/avalon_mon_pkg.sv
// avalon_mon_pkg: shared mode/error encodings and sizing helpers for the Avalon-MM monitor
package avalon_mon_pkg;
  typedef enum logic [2:0] {
    M_WAITREQ    = 3'd0,
    M_FIXEDWAIT  = 3'd1,
    M_PIPE_VAR   = 3'd2,
    M_PIPE_FIXED = 3'd3,
    M_BURST      = 3'd4
  } avalon_mode_t;
  localparam int NB_ERR = 7;
  typedef enum logic [2:0] {
    E_RW_OVERLAP   = 3'd0,
    E_HOLD         = 3'd1,
    E_SPURIOUS_RDV = 3'd2,
    E_OVERFLOW     = 3'd3,
    E_LATENCY      = 3'd4,
    E_BURST        = 3'd5,
    E_FIXED_WAIT   = 3'd6
  } err_idx_t;
  function automatic int width_of_pending(input int maxpending);
    return $clog2(maxpending + 1);
  endfunction
endpackage

// File: rtl/avalon_latency_tracker.sv
// avalon_latency_tracker: flags any readdatavalid that does not land exactly FIXEDDELAY cycles after its read
module avalon_latency_tracker #(
  parameter int FIXEDDELAY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic rdv_i,
  output logic err_o
);
  logic [FIXEDDELAY-1:0] sr_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr_q <= '0;
    else      sr_q <= (sr_q << 1) | FIXEDDELAY'(load_i);
  end
  assign err_o = rdv_i != sr_q[FIXEDDELAY-1];
endmodule

// File: rtl/avalon_protocol_monitor.sv
// avalon_protocol_monitor: passive Avalon-MM link checker with sticky error flags and counters
// Modes: 0 waitrequest, 1 fixed wait, 2 pipelined variable, 3 pipelined fixed, 4 burst.
module avalon_protocol_monitor
  import avalon_mon_pkg::*;
#(
  parameter int AVALONMODE  = 0,
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8,
  parameter int READDELAY   = 1,
  parameter int WRITEDELAY  = 2,
  parameter int FIXEDDELAY  = 2,
  parameter int MAXPENDING  = 8,
  parameter int MAXBURST    = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NBADDRBITS-1:0]                   address,
  input  logic [NBDATABYTES-1:0]                  byteenable,
  input  logic [8*NBDATABYTES-1:0]                writedata,
  input  logic [8*NBDATABYTES-1:0]                readdata,
  input  logic                                    read,
  input  logic                                    write,
  input  logic                                    waitrequest,
  input  logic                                    readdatavalid,
  input  logic                                    beginbursttransfer,
  input  logic [7:0]                              burstcount,
  input  logic                                    clr,
  output logic [NB_ERR-1:0]                       err_flags,
  output logic                                    err_valid,
  output logic [2:0]                              err_first,
  output logic [15:0]                             err_count,
  output logic [15:0]                             txn_count,
  output logic [width_of_pending(MAXPENDING)-1:0] rd_pending
);
  localparam int PW       = width_of_pending(MAXPENDING);
  localparam bit FW_EN    = AVALONMODE == int'(M_FIXEDWAIT);
  localparam bit HOLD_EN  = !FW_EN;
  localparam bit PEND_EN  = AVALONMODE >= int'(M_PIPE_VAR);
  localparam bit LAT_EN   = AVALONMODE == int'(M_PIPE_FIXED);
  localparam bit BURST_EN = AVALONMODE == int'(M_BURST);
  logic cmd, accept, rd_acc, wr_acc, first_cycle, rdv_eff, unused_readdata;
  logic e_rw, e_hold, e_spur, e_ovf, e_lat, e_burst, e_fw;
  logic [NB_ERR-1:0] e, flags_q, flags_d;
  logic [2:0] first_q, first_d, lowest;
  logic [15:0] ecnt_q, ecnt_d, ecnt_base, txn_q, txn_d;
  logic [NBADDRBITS-1:0] addr_q, baddr_q;
  logic [NBDATABYTES-1:0] be_q;
  logic [8*NBDATABYTES-1:0] wd_q;
  logic [7:0] bc_q, bbc_q, beats_q, beats_d, win_q, win_d, win_cnt;
  logic rd_q, wr_q, stall_q;
  logic [PW-1:0] pend_q, pend_d;
  logic [8:0] n;
  logic [9:0] tot;
  assign unused_readdata = ^readdata;
  assign cmd = read | write;
  // Fixed-wait window: remaining cycles including the current one, started on a rising command.
  assign win_cnt = win_q != 8'd0 ? win_q : read && !rd_q ? 8'(READDELAY + 1) : write && !wr_q ? 8'(WRITEDELAY + 1) : 8'd0;
  assign e_fw = FW_EN && win_q != 8'd0 && (read != rd_q || write != wr_q || address != addr_q || byteenable != be_q);
  assign win_d = !FW_EN || e_fw || win_cnt == 8'd0 ? 8'd0 : win_cnt - 8'd1;
  assign accept = FW_EN ? (win_cnt == 8'd1 && cmd && !e_fw) : (cmd && !waitrequest);
  assign rd_acc = accept && read;
  assign wr_acc = accept && write;
  assign n = PEND_EN && rd_acc ? (BURST_EN ? {1'b0, burstcount} : 9'd1) : 9'd0;
  assign rdv_eff = PEND_EN && readdatavalid && pend_q != '0;
  assign tot = 10'(pend_q) + 10'(n) - 10'(rdv_eff);
  assign pend_d = tot > 10'(MAXPENDING) ? PW'(MAXPENDING) : PW'(tot);
  assign beats_d = !BURST_EN || !wr_acc ? beats_q : beats_q != 8'd0 ? beats_q - 8'd1 : burstcount != 8'd0 ? burstcount - 8'd1 : 8'd0;
  assign first_cycle = cmd && !stall_q && beats_q == 8'd0;
  assign e_rw = read && write;
  assign e_hold = HOLD_EN && stall_q && (address != addr_q || byteenable != be_q || read != rd_q || write != wr_q || writedata != wd_q || burstcount != bc_q);
  assign e_spur = PEND_EN && readdatavalid && pend_q == '0;
  assign e_ovf = PEND_EN && tot > 10'(MAXPENDING);
  assign e_burst = BURST_EN && ((accept && (burstcount == 8'd0 || burstcount > 8'(MAXBURST))) || (beginbursttransfer && !first_cycle) || (beats_q != 8'd0 && (read || (write && (address != baddr_q || burstcount != bbc_q)))));
  generate
    if (LAT_EN) begin : g_lat
      avalon_latency_tracker #(.FIXEDDELAY(FIXEDDELAY)) u_lat (
        .clk    (clk),
        .rst    (rst),
        .load_i (rd_acc),
        .rdv_i  (readdatavalid),
        .err_o  (e_lat)
      );
    end else begin : g_nolat
      assign e_lat = 1'b0;
    end
  endgenerate
  assign e = {e_fw, e_burst, e_lat, e_ovf, e_spur, e_hold, e_rw};
  always_comb begin
    lowest = 3'd0;
    for (int i = NB_ERR - 1; i >= 0; i--) lowest = e[i] ? 3'(i) : lowest;
  end
  // A clear in the same cycle as an error wipes the old state first, then records the new error.
  assign flags_d = (clr ? '0 : flags_q) | e;
  assign first_d = (clr || flags_q == '0) && e != '0 ? lowest : clr ? 3'd0 : first_q;
  assign ecnt_base = clr ? 16'd0 : ecnt_q;
  assign ecnt_d = ecnt_base + 16'(e != '0 && ecnt_base != 16'hFFFF);
  assign txn_d = (clr ? 16'd0 : txn_q) + 16'(accept);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= '0;
      first_q <= '0;
      ecnt_q  <= '0;
      txn_q   <= '0;
      pend_q  <= '0;
      beats_q <= '0;
      win_q   <= '0;
      addr_q  <= '0;
      baddr_q <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      bc_q    <= '0;
      bbc_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      flags_q <= flags_d;
      first_q <= first_d;
      ecnt_q  <= ecnt_d;
      txn_q   <= txn_d;
      pend_q  <= pend_d;
      beats_q <= beats_d;
      win_q   <= win_d;
      addr_q  <= address;
      be_q    <= byteenable;
      wd_q    <= writedata;
      bc_q    <= burstcount;
      rd_q    <= read;
      wr_q    <= write;
      stall_q <= cmd && waitrequest;
      if (BURST_EN && wr_acc && beats_q == 8'd0) begin
        baddr_q <= address;
        bbc_q   <= burstcount;
      end
    end
  end
  assign err_flags  = flags_q;
  assign err_valid  = |flags_q;
  assign err_first  = first_q;
  assign err_count  = ecnt_q;
  assign txn_count  = txn_q;
  assign rd_pending = pend_q;
endmodule
